// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: op codes, ALU function
// codes, register/func widths, status flag bit positions and FSM states.
package alu_issue_ctrl_pkg;

  localparam int REG_WIDTH = 8;
  localparam int OPP_WIDTH = 3;

  // Status (P) register bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  // Request op codes; 4'hD..4'hF are illegal
  typedef enum logic [3:0] {
    OP_LD  = 4'h0,
    OP_ADC = 4'h1,
    OP_SBC = 4'h2,
    OP_AND = 4'h3,
    OP_ORA = 4'h4,
    OP_EOR = 4'h5,
    OP_ASL = 4'h6,
    OP_ROL = 4'h7,
    OP_LSR = 4'h8,
    OP_ROR = 4'h9,
    OP_CMP = 4'hA,
    OP_INC = 4'hB,
    OP_DEC = 4'hC
  } op_e;

  // Function codes presented to the ALU
  typedef enum logic [OPP_WIDTH-1:0] {
    NO_OPP  = 3'd0,
    ALU_SUM = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SR  = 3'd5
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True for legal ops that need an ALU round trip (everything but LD)
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op != OP_LD) && (op <= OP_DEC);
  endfunction

  // Replace N and Z in a status byte according to a result byte
  function automatic logic [REG_WIDTH-1:0] set_nz(input logic [REG_WIDTH-1:0] p,
                                                  input logic [REG_WIDTH-1:0] r);
    logic [REG_WIDTH-1:0] q;
    q         = p;
    q[FLAG_N] = r[REG_WIDTH-1];
    q[FLAG_Z] = (r == '0);
    return q;
  endfunction

endpackage

// File: rtl/alu_op_map.sv
// Combinational op decode: ALU function, second operand, operand inversion,
// carry-in and which flags the ALU result is allowed to update.
module alu_op_map
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0]           op,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  input  logic                 carry,
  output logic [OPP_WIDTH-1:0] func,
  output logic [REG_WIDTH-1:0] operand_b,
  output logic                 invert,
  output logic                 carry_in,
  output logic                 c_from_alu,
  output logic                 v_from_alu
);

  logic carry_eff;

  // Per-op ALU setup; the ALU subtracts when invert is set, so the carry
  // it sees is the borrow, hence carry_in = Ceff ^ invert below.
  always_comb begin
    func       = NO_OPP;
    operand_b  = '0;
    invert     = 1'b0;
    carry_eff  = 1'b0;
    c_from_alu = 1'b0;
    v_from_alu = 1'b0;
    case (op)
      OP_ADC: begin
        func = ALU_SUM; operand_b = b; carry_eff = carry;
        c_from_alu = 1'b1; v_from_alu = 1'b1;
      end
      OP_SBC: begin
        func = ALU_SUM; operand_b = b; invert = 1'b1; carry_eff = carry;
        c_from_alu = 1'b1; v_from_alu = 1'b1;
      end
      OP_CMP: begin
        func = ALU_SUM; operand_b = b; invert = 1'b1; carry_eff = 1'b1;
        c_from_alu = 1'b1;
      end
      OP_AND: begin func = ALU_AND; operand_b = b; end
      OP_ORA: begin func = ALU_OR;  operand_b = b; end
      OP_EOR: begin func = ALU_XOR; operand_b = b; end
      // Left shifts are a + a through the adder
      OP_ASL: begin func = ALU_SUM; operand_b = a; c_from_alu = 1'b1; end
      OP_ROL: begin
        func = ALU_SUM; operand_b = a; carry_eff = carry; c_from_alu = 1'b1;
      end
      // Right shifts shift carry_in into bit 7
      OP_LSR: begin func = ALU_SR; c_from_alu = 1'b1; end
      OP_ROR: begin func = ALU_SR; carry_eff = carry; c_from_alu = 1'b1; end
      OP_INC: begin func = ALU_SUM; operand_b = '0; carry_eff = 1'b1; end
      OP_DEC: begin func = ALU_SUM; operand_b = '1; end
      default: ;
    endcase
  end

  assign carry_in = carry_eff ^ invert;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one request at a time, drives the external
// ALU from holding registers, derives N/Z/C/V and returns a one-cycle
// response. LD and illegal ops complete without touching the ALU.
// Optional WAIT watchdog enabled by defining ALU_TIMEOUT_EN.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 phi2,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [REG_WIDTH-1:0] req_a,
  input  logic [REG_WIDTH-1:0] req_b,
  input  logic [REG_WIDTH-1:0] status_in,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  output logic [OPP_WIDTH-1:0] alu_func,
  output logic                 alu_carry_in,
  output logic                 alu_invert,
  output logic [REG_WIDTH-1:0] alu_status_in,
  input  logic [REG_WIDTH-1:0] alu_dout,
  input  logic [REG_WIDTH-1:0] alu_status_out,
  input  logic                 alu_wout,
  output logic                 rsp_valid,
  output logic [REG_WIDTH-1:0] rsp_result,
  output logic [REG_WIDTH-1:0] rsp_status,
  output logic                 rsp_dest_we,
  output logic                 rsp_err
);

  state_e state_reg, state_next;

  logic [3:0]           op_reg;
  logic [REG_WIDTH-1:0] a_reg, b_reg, status_reg;
  logic [REG_WIDTH-1:0] result_reg, result_next;
  logic [REG_WIDTH-1:0] rsp_status_reg, rsp_status_next;
  logic                 dest_we_reg, dest_we_next;
  logic                 err_reg, err_next;

  logic                 accept, active;
  logic [OPP_WIDTH-1:0] map_func;
  logic [REG_WIDTH-1:0] map_b;
  logic                 map_invert, map_carry_in, map_c_from_alu, map_v_from_alu;
  logic [REG_WIDTH-1:0] alu_flags;
  logic                 unused_status_bits;

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

  // A watchdog shorter than one cycle is meaningless; leave room for it.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
  end

  alu_op_map u_map (
    .op         (op_reg),
    .a          (a_reg),
    .b          (b_reg),
    .carry      (status_reg[FLAG_C]),
    .func       (map_func),
    .operand_b  (map_b),
    .invert     (map_invert),
    .carry_in   (map_carry_in),
    .c_from_alu (map_c_from_alu),
    .v_from_alu (map_v_from_alu)
  );

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign active    = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);

  // ALU sees a quiet bus except while an op is issued or awaited
  assign alu_func      = active ? map_func : NO_OPP;
  assign alu_a         = active ? a_reg : '0;
  assign alu_b         = active ? map_b : '0;
  assign alu_invert    = active ? map_invert : 1'b0;
  assign alu_carry_in  = active ? map_carry_in : 1'b0;
  assign alu_status_in = active ? status_reg : '0;

  assign rsp_valid   = (state_reg == ST_DONE);
  assign rsp_result  = result_reg;
  assign rsp_status  = rsp_status_reg;
  assign rsp_dest_we = dest_we_reg;
  assign rsp_err     = err_reg;

  // Only the ALU carry and overflow bits are meaningful to us
  assign unused_status_bits = ^{alu_status_out[7], alu_status_out[5:1]};

  // New P from an ALU result: N/Z from the byte, C/V only where the op owns them
  always_comb begin
    alu_flags = set_nz(status_reg, alu_dout);
    if (map_c_from_alu) alu_flags[FLAG_C] = alu_status_out[FLAG_C] ^ map_invert;
    if (map_v_from_alu) alu_flags[FLAG_V] = alu_status_out[FLAG_V];
  end

  // Next-state and response loading
  always_comb begin
    state_next      = state_reg;
    result_next     = result_reg;
    rsp_status_next = rsp_status_reg;
    dest_we_next    = dest_we_reg;
    err_next        = err_reg;
`ifdef ALU_TIMEOUT_EN
    cnt_next        = '0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_alu_op(req_op)) begin
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_DONE;
            if (req_op == OP_LD) begin
              // LD passes the source operand straight through
              result_next     = req_a;
              rsp_status_next = set_nz(status_in, req_a);
              dest_we_next    = 1'b1;
              err_next        = 1'b0;
            end else begin
              result_next     = '0;
              rsp_status_next = status_in;
              dest_we_next    = 1'b0;
              err_next        = 1'b1;
            end
          end
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (alu_wout) begin
          state_next      = ST_DONE;
          result_next     = alu_dout;
          rsp_status_next = alu_flags;
          dest_we_next    = (op_reg != OP_CMP);
          err_next        = 1'b0;
        end
`ifdef ALU_TIMEOUT_EN
        else if (cnt_reg == CNT_LAST) begin
          state_next      = ST_DONE;
          result_next     = '0;
          rsp_status_next = status_reg;
          dest_we_next    = 1'b0;
          err_next        = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge phi2) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Request holding registers and registered response
  always_ff @(posedge phi2) begin
    if (!reset_n) begin
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      status_reg     <= '0;
      result_reg     <= '0;
      rsp_status_reg <= '0;
      dest_we_reg    <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      if (accept) begin
        op_reg     <= req_op;
        a_reg      <= req_a;
        b_reg      <= req_b;
        status_reg <= status_in;
      end
      result_reg     <= result_next;
      rsp_status_reg <= rsp_status_next;
      dest_we_reg    <= dest_we_next;
      err_reg        <= err_next;
    end
  end

`ifdef ALU_TIMEOUT_EN
  // WAIT watchdog counter, cleared whenever not waiting
  always_ff @(posedge phi2) begin
    if (!reset_n) cnt_reg <= '0;
    else          cnt_reg <= cnt_next;
  end
`endif

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max cycles in WAIT before abort (used only when ALU_TIMEOUT_EN defined).
REQ-002 SHALL have port: phi2  input  1  clock, all state updates on posedge.
REQ-003 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req_valid input 1, request present; req_ready output 1, controller idle; req_op input 4, operation code.
REQ-005 SHALL have ports: req_a input 8, accumulator/source operand; req_b input 8, memory operand; status_in input 8, current P register.
REQ-006 SHALL have ALU-side outputs: alu_a 8, alu_b 8, alu_func OPP_WIDTH, alu_carry_in 1, alu_invert 1, alu_status_in 8.
REQ-007 SHALL have ALU-side inputs: alu_dout 8, ALU result; alu_status_out 8, ALU flags; alu_wout 1, ALU result valid.
REQ-008 SHALL have response outputs: rsp_valid 1, rsp_result 8, rsp_status 8, rsp_dest_we 1 (write result to register), rsp_err 1.

Function
REQ-009 SHALL decode req_op: 0 LD, 1 ADC, 2 SBC, 3 AND, 4 ORA, 5 EOR, 6 ASL, 7 ROL, 8 LSR, 9 ROR, A CMP, B INC, C DEC; D-F illegal.
REQ-010 SHALL map ops to ALU: ADC/SBC/CMP/ASL/ROL/INC/DEC -> SUM; AND/ORA/EOR -> AND/OR/XOR; LSR/ROR -> SR.
REQ-011 SHALL drive alu_b: req_b for ADC/SBC/CMP/logic; req_a for ASL/ROL; 0x00 for INC; 0xFF for DEC; 0x00 for shifts.
REQ-012 SHALL drive alu_invert=1 for SBC and CMP only, else 0.
REQ-013 SHALL drive alu_carry_in = Ceff XOR alu_invert, where Ceff = P.C for ADC/SBC/ROL/ROR, 1 for CMP/INC, 0 for ASL/LSR/DEC/logic.
REQ-014 SHALL compute flags itself: N = result[7], Z = (result == 0x00), for every op including LD/INC/DEC.
REQ-015 SHALL take C = alu_status_out[0] XOR alu_invert for SUM-mapped ops except INC/DEC; C = alu_status_out[0] for LSR/ROR; C unchanged for LD/logic/INC/DEC.
REQ-016 SHALL take V = alu_status_out[6] for ADC/SBC only; all other P bits pass through from status_in.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; req_ready = 1 only in IDLE.
REQ-018 SHALL in IDLE drive alu_func = NO_OPP; on req_valid && req_ready capture req_op, req_a, req_b, status_in into holding registers.
REQ-019 SHALL transition IDLE -> DONE for LD and illegal ops (no ALU issue), IDLE -> ISSUE otherwise.
REQ-020 SHALL in ISSUE and WAIT drive alu_func and operands from holding registers; ISSUE ignores alu_wout and moves to WAIT after one cycle.
REQ-021 SHALL in WAIT, on first edge with alu_wout=1, register alu_dout and derived flags and move to DONE.
REQ-022 SHALL in DONE assert rsp_valid for exactly one cycle, drive alu_func = NO_OPP, then return to IDLE.
REQ-023 SHALL drive rsp_dest_we = 1 for all legal ops except CMP; illegal ops give rsp_err=1, rsp_dest_we=0, rsp_status = captured status_in.
REQ-024 SHALL give latency accept->rsp_valid of 1 cycle for LD/illegal, minimum 3 cycles for ALU ops.
REQ-025 SHALL hold rsp_result/rsp_status stable outside DONE; rsp_valid=0 outside DONE.

Reset
REQ-026 SHALL on reset_n=0 at a phi2 edge enter IDLE, clear holding registers, rsp_* = 0, alu_func = NO_OPP, alu_a/alu_b = 0, alu_carry_in/alu_invert = 0, timeout counter = 0.
REQ-027 SHALL abandon any in-flight op on reset with no rsp_valid pulse for it.

Configuration
REQ-028 SHALL support macro ALU_TIMEOUT_EN: defined -> counter counts cycles in WAIT; on reaching TIMEOUT_CYCLES go DONE with rsp_err=1, rsp_dest_we=0, rsp_status = captured status_in.
REQ-029 SHALL, without ALU_TIMEOUT_EN, wait in WAIT indefinitely, omit the counter, and raise rsp_err only for illegal ops.

Structure
REQ-030 SHALL place op codes, ALU func codes, REG_WIDTH, OPP_WIDTH, flag bit indices (C0 Z1 I2 D3 B4 V6 N7) in the shared defines package.
REQ-031 SHALL factor the combinational op->func/b/invert/carry mapping into sub-module alu_op_map.

Verification
REQ-032 SHALL test ADC: P.C=0, a=0x50, b=0x50 -> rsp_result 0xA0, N=1 V=1 Z=0 C=0, rsp_dest_we=1.
REQ-033 SHALL test SBC: P.C=1, a=0x05, b=0x06 -> 0xFF, C=0 N=1; CMP a=0x40 b=0x40 -> Z=1 C=1 rsp_dest_we=0.
REQ-034 SHALL test ROR: P.C=1, a=0x01 -> 0x80, C=1 N=1; DEC a=0x01 -> 0x00, Z=1, C unchanged.
REQ-035 SHALL test LD 0x00: rsp_valid one cycle after accept, Z=1, alu_func never leaves NO_OPP; op 0xE -> rsp_err=1.
REQ-036 SHALL test ALU_TIMEOUT_EN with alu_wout held 0: rsp_err=1 after 16 WAIT cycles, P unchanged; reset_n=0 mid-WAIT -> IDLE next edge, no rsp_valid.
